// File: rtl/aes_pkg.sv
// Shared AES types and constants for the iterative encryption controller.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES128_NR   = 10;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } seq_state_t;

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Plaintext-in / ciphertext-out valid/ready streams of the round sequencer.
interface aes_round_sequencer_if;

    logic                in_valid;
    logic                in_ready;
    aes_pkg::aes_block_t in_data;
    logic                out_valid;
    logic                out_ready;
    aes_pkg::aes_block_t out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/aes_round_counter.sv
// Loadable round counter; terminal flags the final round (count == NR).
module aes_round_counter #(
    parameter int NR     = 10,
    parameter int KIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [KIDX_W-1:0] load_val,
    input  logic              inc,
    output logic [KIDX_W-1:0] count,
    output logic              terminal
);

    logic [KIDX_W-1:0] count_reg;

    // clr beats load so an abort always wins over a new block
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (inc) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count    = count_reg;
    assign terminal = (count_reg == KIDX_W'(NR));

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES controller: owns the state register and round counter and
// steers an external combinational round datapath plus round-key lookup.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR     = AES128_NR,
    parameter int KIDX_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    aes_round_sequencer_if.slave  bus,
    output logic [KIDX_W-1:0]     key_idx,
    input  aes_block_t            key_data,
    output aes_block_t            dp_in,
    output logic                  dp_last,
    input  aes_block_t            dp_out,
    output logic                  busy,
    input  logic                  flush
);

    seq_state_t        fsm_reg, fsm_next;
    aes_block_t        state_reg, state_next;
    logic [KIDX_W-1:0] round;
    logic              round_last;
    logic              cnt_clr, cnt_load, cnt_inc;

    aes_round_counter #(
        .NR     (NR),
        .KIDX_W (KIDX_W)
    ) u_round_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (KIDX_W'(1)),
        .inc      (cnt_inc),
        .count    (round),
        .terminal (round_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_reg   <= IDLE;
            state_reg <= '0;
        end else begin
            fsm_reg   <= fsm_next;
            state_reg <= state_next;
        end
    end

    always_comb begin
        fsm_next      = fsm_reg;
        state_next    = state_reg;
        cnt_clr       = 1'b0;
        cnt_load      = 1'b0;
        cnt_inc       = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        key_idx       = '0;
        dp_last       = 1'b0;

        case (fsm_reg)
            IDLE: begin
                bus.in_ready = 1'b1;
                // key index 0 is the initial AddRoundKey whitening key
                if (bus.in_valid && !flush) begin
                    state_next = bus.in_data ^ key_data;
                    cnt_load   = 1'b1;
                    fsm_next   = ROUND;
                end
            end
            ROUND: begin
                key_idx    = round;
                dp_last    = round_last;
                state_next = dp_out ^ key_data;
                if (round_last) begin
                    cnt_clr  = 1'b1;
                    fsm_next = DONE;
                end else begin
                    cnt_inc  = 1'b1;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    fsm_next = IDLE;
                end
            end
            default: begin
                fsm_next = IDLE;
            end
        endcase

        if (flush) begin
            fsm_next = IDLE;
            cnt_clr  = 1'b1;
        end
    end

    assign bus.out_data = state_reg;
    assign dp_in        = state_reg;
    assign busy         = (fsm_reg != IDLE);

endmodule
